// File: rtl/sd_cmd_ctrl.sv
// SPI-mode SD command engine: sends one 48-bit command frame with CRC7, polls for the R1
// response with a bounded timeout, then clocks out 8 trailer periods with chip-select released.
module sd_cmd_ctrl #(
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic        resp_timeout,
    output logic        busy,
    input  logic        SD_MISO,
    output logic        SD_CK,
    output logic        SD_MOSI,
    output logic        SD_CSn
);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWait,
        StResp,
        StTrail
    } state_e;

    localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
    localparam logic [9:0] PollLast = 10'(RESP_TIMEOUT - 1);

    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        csn_q, csn_d;
    logic [47:0] sh_q, sh_d;
    logic [5:0]  bit_q, bit_d;
    logic [9:0]  poll_q, poll_d;
    logic        end_q, end_d;
    logic [7:0]  r1_q, r1_d;
    logic        tmo_q, tmo_d;
    logic        rv_q, rv_d;

    logic [39:0] hdr;
    logic [47:0] frame;
    logic        tick;
    logic        rise;
    logic        fall;

    assign hdr   = {2'b01, cmd_idx, cmd_arg};
    assign frame = {hdr, crc7(hdr), 1'b1};

    // The divider only runs while a transfer is in flight; each tick is one SD_CK edge.
    assign tick = (state_q != StIdle) && (div_q == DivLast);
    assign rise = tick & ~sck_q;
    assign fall = tick & sck_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        poll_d  = poll_q;
        end_d   = end_q;
        r1_d    = r1_q;
        tmo_d   = tmo_q;
        rv_d    = 1'b0;

        if (state_q != StIdle) begin
            if (tick) begin
                div_d = '0;
                sck_d = ~sck_q;
            end else begin
                div_d = div_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    // Bit 47 goes out now; the shifter holds bits 46..0 for the falling edges.
                    sh_d    = {frame[46:0], 1'b1};
                    mosi_d  = frame[47];
                    csn_d   = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    poll_d  = '0;
                    end_d   = 1'b0;
                    r1_d    = 8'hFF;
                    tmo_d   = 1'b0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (fall) begin
                    if (bit_q == 6'd47) begin
                        mosi_d  = 1'b1;
                        bit_d   = '0;
                        state_d = StWait;
                    end else begin
                        mosi_d = sh_q[47];
                        sh_d   = {sh_q[46:0], 1'b1};
                        bit_d  = bit_q + 6'd1;
                    end
                end
            end
            StWait: begin
                if (rise && !end_q) begin
                    if (!SD_MISO) begin
                        r1_d    = {r1_q[6:0], 1'b0};
                        bit_d   = '0;
                        state_d = StResp;
                    end else begin
                        poll_d = poll_q + 10'd1;
                        if (poll_q == PollLast) begin
                            tmo_d = 1'b1;
                            r1_d  = 8'hFF;
                            end_d = 1'b1;
                        end
                    end
                end
                // CSn rises on the edge that drives SD_CK low, so SCK is never high with CSn up.
                if (fall && end_q) begin
                    csn_d   = 1'b1;
                    end_d   = 1'b0;
                    bit_d   = '0;
                    state_d = StTrail;
                end
            end
            StResp: begin
                if (rise) begin
                    r1_d  = {r1_q[6:0], SD_MISO};
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd6) begin
                        end_d = 1'b1;
                    end
                end
                if (fall && end_q) begin
                    csn_d   = 1'b1;
                    end_d   = 1'b0;
                    bit_d   = '0;
                    state_d = StTrail;
                end
            end
            StTrail: begin
                if (fall) begin
                    if (bit_q == 6'd7) begin
                        // The 8th trailer fall leaves SD_CK low and the divider at zero.
                        bit_d   = '0;
                        rv_d    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            csn_q   <= 1'b1;
            sh_q    <= '1;
            bit_q   <= '0;
            poll_q  <= '0;
            end_q   <= 1'b0;
            r1_q    <= 8'hFF;
            tmo_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            poll_q  <= poll_d;
            end_q   <= end_d;
            r1_q    <= r1_d;
            tmo_q   <= tmo_d;
            rv_q    <= rv_d;
        end
    end

    // resp_valid lands exactly 64 SD_CK periods after CSn falls when the start bit is on the
    // first poll; there is no extra state-transition cycle.
    assign cmd_ready    = (state_q == StIdle);
    assign busy         = ~cmd_ready;
    assign resp_valid   = rv_q;
    assign resp_r1      = r1_q;
    assign resp_timeout = tmo_q;
    assign SD_CK        = sck_q;
    assign SD_MOSI      = mosi_q;
    assign SD_CSn       = csn_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl: two instances (CLK_DIV=1 and CLK_DIV=3) each with a simple
// SPI card model that captures MOSI on SD_CK rises and drives MISO on SD_CK falls.
module tb_sd_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;

    logic       cmd_valid1, cmd_ready1, rv1, tmo1, busy1, ck1, mosi1, csn1;
    logic [7:0] r11;
    logic       miso1 = 1'b1;
    logic       cmd_valid3, cmd_ready3, rv3, tmo3, busy3, ck3, mosi3, csn3;
    logic [7:0] r13;
    logic       miso3 = 1'b1;

    logic [63:0] pat1 = '1;
    logic [63:0] pat3 = '1;
    logic [47:0] rx1 = '0;
    logic [47:0] rx3 = '0;
    int nf1 = 0, nr1 = 0, nf3 = 0, nr3 = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sd_cmd_ctrl #(.CLK_DIV(1), .RESP_TIMEOUT(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .resp_valid(rv1), .resp_r1(r11),
        .resp_timeout(tmo1), .busy(busy1), .SD_MISO(miso1), .SD_CK(ck1), .SD_MOSI(mosi1),
        .SD_CSn(csn1)
    );

    sd_cmd_ctrl #(.CLK_DIV(3), .RESP_TIMEOUT(64)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .resp_valid(rv3), .resp_r1(r13),
        .resp_timeout(tmo3), .busy(busy3), .SD_MISO(miso3), .SD_CK(ck3), .SD_MOSI(mosi3),
        .SD_CSn(csn3)
    );

    // Card model: poll bit j of pat (MSB first) appears after falling edge 48+j.
    always @(negedge ck1 or posedge csn1) begin
        if (csn1) begin
            nf1 <= 0;
            miso1 <= 1'b1;
        end else begin
            nf1 <= nf1 + 1;
            if (nf1 >= 47 && nf1 <= 110) miso1 <= pat1[110 - nf1];
            else miso1 <= 1'b1;
        end
    end

    always @(posedge ck1 or posedge csn1) begin
        if (csn1) begin
            nr1 <= 0;
        end else begin
            if (nr1 < 48) rx1 <= {rx1[46:0], mosi1};
            nr1 <= nr1 + 1;
        end
    end

    always @(negedge ck3 or posedge csn3) begin
        if (csn3) begin
            nf3 <= 0;
            miso3 <= 1'b1;
        end else begin
            nf3 <= nf3 + 1;
            if (nf3 >= 47 && nf3 <= 110) miso3 <= pat3[110 - nf3];
            else miso3 <= 1'b1;
        end
    end

    always @(posedge ck3 or posedge csn3) begin
        if (csn3) begin
            nr3 <= 0;
        end else begin
            if (nr3 < 48) rx3 <= {rx3[46:0], mosi3};
            nr3 <= nr3 + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command on the CLK_DIV=1 instance and check the whole transaction.
    task automatic run1(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                        input int exp_lat, input logic [47:0] exp_frame,
                        input logic [7:0] exp_r1, input logic exp_tmo);
        int   c;
        int   trail;
        logic pck;
        @(negedge clk);
        check({tag, "_ready"}, cmd_ready1, 1);
        cmd_idx    = idx;
        cmd_arg    = arg;
        cmd_valid1 = 1'b1;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        check({tag, "_csn_low"}, csn1, 0);
        check({tag, "_busy"}, busy1, 1);
        c     = 1;
        trail = 0;
        pck   = ck1;
        while (!rv1 && c < 4000) begin
            @(negedge clk);
            c++;
            if (ck1 && !pck && csn1) trail++;
            pck = ck1;
        end
        check({tag, "_latency"}, c - 1, exp_lat);
        check({tag, "_frame"}, rx1, exp_frame);
        check({tag, "_r1"}, r11, exp_r1);
        check({tag, "_timeout"}, tmo1, exp_tmo);
        check({tag, "_trail_clks"}, trail, 8);
        check({tag, "_idle_pins"}, {ck1, mosi1, csn1, cmd_ready1}, 4'b0111);
        @(negedge clk);
        check({tag, "_rv_pulse"}, rv1, 0);
    endtask

    initial begin
        int   c;
        int   cnt;
        int   run;
        int   phase_err;
        int   mosi_err;
        logic started;
        logic pck;
        logic pmosi;

        rst_n      = 1'b0;
        cmd_valid1 = 1'b0;
        cmd_valid3 = 1'b0;
        cmd_idx    = '0;
        cmd_arg    = '0;
        repeat (3) @(negedge clk);
        check("rst_ck", ck1, 0);
        check("rst_mosi", mosi1, 1);
        check("rst_csn", csn1, 1);
        check("rst_ready", cmd_ready1, 1);
        check("rst_busy", busy1, 0);
        check("rst_rv", rv1, 0);
        check("rst_r1", r11, 8'hFF);
        check("rst_tmo", tmo1, 0);
        check("rst3_pins", {ck3, mosi3, csn3, cmd_ready3}, 4'b0111);
        rst_n = 1'b1;

        // CMD0: two 0xFF poll bytes, then R1 = 0x01 (start bit on poll 17).
        pat1 = {16'hFFFF, 8'h01, 40'hFF_FFFF_FFFF};
        run1("cmd0", 6'd0, 32'h0, 160, 48'h40_0000_0000_95, 8'h01, 1'b0);

        // CMD8: R1 = 0x01 on the very first poll bit -> 64 periods.
        pat1 = {8'h01, 56'hFF_FFFF_FFFF_FFFF};
        run1("cmd8", 6'd8, 32'h0000_01AA, 128, 48'h48_0000_01AA_87, 8'h01, 1'b0);

        // CMD55 with MISO stuck high: 48 + 64 + 8 periods.
        pat1 = '1;
        run1("cmd55_to", 6'd55, 32'h0, 240, 48'h77_0000_0000_65, 8'hFF, 1'b1);

        // Reset during SEND after the 20th rising edge.
        pat1 = {8'h01, 56'hFF_FFFF_FFFF_FFFF};
        @(negedge clk);
        cmd_idx    = 6'd8;
        cmd_arg    = 32'h0000_01AA;
        cmd_valid1 = 1'b1;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        c = 0;
        while (nr1 < 20 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("abort_at_bit20", nr1, 20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_pins", {ck1, mosi1, csn1, cmd_ready1, rv1}, 5'b01110);
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (rv1 || !cmd_ready1) cnt++;
        end
        check("abort_no_resp", cnt, 0);
        run1("cmd0_after_rst", 6'd0, 32'h0, 128, 48'h40_0000_0000_95, 8'h01, 1'b0);

        // Pulse while busy is ignored; held request is accepted in the resp_valid cycle.
        @(negedge clk);
        cmd_idx    = 6'd0;
        cmd_arg    = 32'h0;
        cmd_valid1 = 1'b1;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        c = 1;
        repeat (20) begin
            @(negedge clk);
            c++;
        end
        check("busy_pulse_busy", busy1, 1);
        cmd_idx    = 6'd8;
        cmd_arg    = 32'h0000_01AA;
        cmd_valid1 = 1'b1;
        @(negedge clk);
        c++;
        cmd_valid1 = 1'b0;
        repeat (10) begin
            @(negedge clk);
            c++;
        end
        cmd_idx    = 6'd55;
        cmd_arg    = 32'h0;
        cmd_valid1 = 1'b1;
        while (!rv1 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        check("b2b_first_latency", c - 1, 128);
        check("b2b_first_frame", rx1, 48'h40_0000_0000_95);
        check("b2b_ready_with_rv", cmd_ready1, 1);
        check("b2b_first_r1", r11, 8'h01);
        @(negedge clk);
        cmd_valid1 = 1'b0;
        check("b2b_second_csn", {csn1, busy1, rv1}, 3'b010);
        c = 1;
        while (!rv1 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        check("b2b_second_latency", c - 1, 128);
        check("b2b_second_frame", rx1, 48'h77_0000_0000_65);

        // CLK_DIV=3: R1 = 0x05 after 4 idle poll bits (start bit on poll 5).
        pat3 = {4'hF, 8'h05, 52'hF_FFFF_FFFF_FFFF};
        @(negedge clk);
        cmd_idx    = 6'd8;
        cmd_arg    = 32'h0000_01AA;
        cmd_valid3 = 1'b1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        c         = 1;
        run       = 0;
        started   = 1'b0;
        phase_err = 0;
        mosi_err  = 0;
        pck       = ck3;
        pmosi     = mosi3;
        while (!rv3 && c < 4000) begin
            @(negedge clk);
            c++;
            if (ck3 != pck) begin
                if (started && run != 3) phase_err++;
                started = 1'b1;
                run     = 1;
            end else begin
                run++;
            end
            if (mosi3 != pmosi && !(pck && !ck3)) mosi_err++;
            pck   = ck3;
            pmosi = mosi3;
        end
        check("div3_latency", c - 1, 408);
        check("div3_phase", phase_err, 0);
        check("div3_mosi_on_fall", mosi_err, 0);
        check("div3_frame", rx3, 48'h48_0000_01AA_87);
        check("div3_r1", r13, 8'h05);
        check("div3_timeout", tmo3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
